// File: rtl/sobel_frame_ctrl.sv
// Frame-level sequencer for the Sobel datapath.
// Raster-scans an IMG_W x IMG_H frame, issues one window read per interior
// pixel, and carries {valid, addr, border} through an LAT-deep delay line so
// each write leaves with its pixel address and a border (write-zero) flag.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start
// SCAN  | emitting one pixel position per unstalled cycle
// DRAIN | flushing the delay line until the last result is written
// FIN   | one-cycle done pulse, then back to IDLE
module sobel_frame_ctrl #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = 12,
    parameter int LAT    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pipe_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_zero,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int DW = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [DW-1:0] DRAIN_TC0 = DW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DW-1:0]       drain_q, drain_d;

    // Delay line: index 0 is the newest entry, index LAT-1 feeds the write port.
    logic [LAT-1:0]              dl_vld_q, dl_vld_d;
    logic [LAT-1:0]              dl_brd_q, dl_brd_d;
    logic [LAT-1:0][ADDR_W-1:0]  dl_addr_q, dl_addr_d;

    logic last_col;
    logic last_row;
    logic border;
    logic push_vld;

    // Position decode for the pixel currently being emitted.
    always_comb begin
        last_col = (col_q == COL_LAST);
        last_row = (row_q == ROW_LAST);
        border   = (row_q == '0) | last_row | (col_q == '0) | last_col;
    end

    // State, scan counters and drain timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic and FSM outputs; stall freezes every advance.
    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        addr_d   = addr_q;
        drain_d  = drain_q;
        push_vld = 1'b0;
        rd_en    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !stall) begin
                    state_d = SCAN;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end

            SCAN: begin
                busy = 1'b1;
                if (!stall) begin
                    rd_en    = ~border;
                    push_vld = 1'b1;
                    addr_d   = addr_q + 1'b1;
                    if (last_col) begin
                        col_d = '0;
                        if (last_row) begin
                            state_d = DRAIN;
                            drain_d = DRAIN_TC0;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                busy = 1'b1;
                if (!stall) begin
                    if (drain_q == '0) begin
                        state_d = FIN;
                    end else begin
                        drain_d = drain_q - 1'b1;
                    end
                end
            end

            FIN: begin
                // Held under stall, so only the unstalled cycle pulses done.
                done = ~stall;
                if (!stall) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Delay line shift; it only moves in lockstep with the datapath enable.
    always_comb begin
        dl_vld_d  = dl_vld_q;
        dl_brd_d  = dl_brd_q;
        dl_addr_d = dl_addr_q;
        if (!stall) begin
            for (int i = LAT - 1; i >= 1; i--) begin
                dl_vld_d[i]  = dl_vld_q[i-1];
                dl_brd_d[i]  = dl_brd_q[i-1];
                dl_addr_d[i] = dl_addr_q[i-1];
            end
            dl_vld_d[0]  = push_vld;
            dl_brd_d[0]  = push_vld & border;
            dl_addr_d[0] = addr_q;
        end
    end

    // Delay line registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_vld_q  <= '0;
            dl_brd_q  <= '0;
            dl_addr_q <= '0;
        end else begin
            dl_vld_q  <= dl_vld_d;
            dl_brd_q  <= dl_brd_d;
            dl_addr_q <= dl_addr_d;
        end
    end

    // Write port and pipeline enable.
    always_comb begin
        pipe_en = ~stall;
        rd_addr = addr_q;
        wr_en   = dl_vld_q[LAT-1] & ~stall;
        wr_addr = dl_addr_q[LAT-1];
        wr_zero = dl_vld_q[LAT-1] & ~stall & dl_brd_q[LAT-1];
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl on a 4x3 frame with LAT=3.
module tb_sobel_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int AW = 12;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          pipe_en;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_zero;
    logic          busy;
    logic          done;

    sobel_frame_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW),
        .LAT   (L)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .stall  (stall),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .pipe_en(pipe_en),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_zero(wr_zero),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    int wr_q[$];
    int wz_q[$];
    int wc_q[$];
    int rd_q[$];
    int done_cnt = 0;
    int done_cyc = -1;

    // Transaction log sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                wr_q.push_back(int'(wr_addr));
                wz_q.push_back(int'(wr_zero));
                wc_q.push_back(cyc);
            end
            if (rd_en) rd_q.push_back(int'(rd_addr));
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        wr_q.delete();
        wz_q.delete();
        wc_q.delete();
        rd_q.delete();
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns the index of the first SCAN cycle.
    task automatic start_frame(output int t0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 80) begin
            tick();
            n++;
        end
        check_val({tag, "_done_seen"}, int'(done_cnt > 0), 1);
        repeat (4) tick();
    endtask

    task automatic check_frame(input string tag, input int t0, input int done_off);
        check_val({tag, "_wr_count"}, wr_q.size(), W * H);
        for (int i = 0; i < wr_q.size(); i++) begin
            check_val($sformatf("%s_wr_addr%0d", tag, i), wr_q[i], i);
            check_val($sformatf("%s_wr_zero%0d", tag, i), wz_q[i], (i == 5 || i == 6) ? 0 : 1);
        end
        check_val({tag, "_rd_count"}, rd_q.size(), 2);
        if (rd_q.size() == 2) begin
            check_val({tag, "_rd_addr0"}, rd_q[0], 5);
            check_val({tag, "_rd_addr1"}, rd_q[1], 6);
        end
        if (wc_q.size() > 0) check_val({tag, "_first_wr_lat"}, wc_q[0] - t0, 3);
        check_val({tag, "_done_offset"}, done_cyc - t0, done_off);
        check_val({tag, "_done_count"}, done_cnt, 1);
        check_val({tag, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int n;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_rd_en", int'(rd_en), 0);
        check_val("rst_rd_addr", int'(rd_addr), 0);
        check_val("rst_wr_en", int'(wr_en), 0);
        check_val("rst_wr_addr", int'(wr_addr), 0);
        check_val("rst_wr_zero", int'(wr_zero), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_pipe_en", int'(pipe_en), 1);
        rst = 1'b0;
        tick();
        stall = 1'b1;
        #1;
        check_val("idle_pipe_en_stalled", int'(pipe_en), 0);
        stall = 1'b0;
        #1;
        check_val("idle_pipe_en_free", int'(pipe_en), 1);

        // Unstalled frame.
        clear_log();
        start_frame(t0);
        check_val("frame1_busy", int'(busy), 1);
        wait_done("frame1");
        check_frame("frame1", t0, 15);

        // Two-cycle stall while centre (1,1) is being requested.
        clear_log();
        start_frame(t0);
        n = 0;
        while (!(rd_en && rd_addr == 12'd5) && n < 40) begin
            tick();
            n++;
        end
        check_val("stall_reach_addr5", int'(rd_addr), 5);
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            check_val($sformatf("stall%0d_rd_en", k), int'(rd_en), 0);
            check_val($sformatf("stall%0d_wr_en", k), int'(wr_en), 0);
            check_val($sformatf("stall%0d_pipe_en", k), int'(pipe_en), 0);
            check_val($sformatf("stall%0d_rd_addr", k), int'(rd_addr), 5);
            check_val($sformatf("stall%0d_wr_addr", k), int'(wr_addr), 2);
            tick();
        end
        stall = 1'b0;
        wait_done("stall");
        check_frame("stall", t0, 17);

        // start during SCAN and during FIN is ignored.
        clear_log();
        start_frame(t0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (cyc < t0 + 15 && n < 40) begin
            tick();
            n++;
        end
        start = 1'b1;
        #1;
        check_val("fin_done_high", int'(done), 1);
        tick();
        start = 1'b0;
        check_val("fin_start_ignored_busy", int'(busy), 0);
        wait_done("restart");
        check_frame("restart", t0, 15);
        repeat (5) tick();
        check_val("restart_no_extra_writes", wr_q.size(), W * H);

        // Reset asserted mid-frame at write address 4.
        clear_log();
        start_frame(t0);
        n = 0;
        while (!(wr_en && wr_addr == 12'd4) && n < 40) begin
            tick();
            n++;
        end
        check_val("pre_rst_wr_addr", int'(wr_addr), 4);
        check_val("pre_rst_wr_zero", int'(wr_zero), 1);
        rst = 1'b1;
        #1;
        check_val("midrst_rd_en", int'(rd_en), 0);
        check_val("midrst_rd_addr", int'(rd_addr), 0);
        check_val("midrst_wr_en", int'(wr_en), 0);
        check_val("midrst_wr_addr", int'(wr_addr), 0);
        check_val("midrst_wr_zero", int'(wr_zero), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_done", int'(done), 0);
        tick();
        rst = 1'b0;
        clear_log();
        repeat (8) tick();
        check_val("post_rst_no_writes", wr_q.size(), 0);
        check_val("post_rst_no_reads", rd_q.size(), 0);
        check_val("post_rst_busy", int'(busy), 0);
        start_frame(t0);
        wait_done("after_rst");
        check_frame("after_rst", t0, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
